// File: rtl/sys_arr_result_drain.sv
// rtl/sys_arr_result_drain.sv - snapshot systolic array results on comp_done and stream them row-major
//
// Ports:
//   clk, nrst           clock, asynchronous active-low reset
//   comp_done           AND of all PE done flags; its rising edge triggers a capture
//   error_in            combined PE error flag, latched into err_out at capture
//   res_in              flattened accumulators, element (r,c) at [(r*K+c)*DW +: DW]
//   out_dat/out_valid/out_ready/out_last/out_idx
//                       result stream, one element per accepted handshake
//   busy                a capture is held and being streamed
//   drain_done          one-cycle pulse after the last element is accepted
//   err_out             error_in as seen at the last accepted capture
//   overrun             sticky: comp_done rose while a stream was in progress
module sys_arr_result_drain #(
    parameter  int M  = 2,
    parameter  int K  = 2,
    parameter  int DW = 32,
    localparam int N  = M * K,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              comp_done,
    input  logic              error_in,
    input  logic [N*DW-1:0]   res_in,
    output logic [DW-1:0]     out_dat,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic [IW-1:0]     out_idx,
    output logic              busy,
    output logic              drain_done,
    output logic              err_out,
    output logic              overrun
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

    state_t          state_q;
    logic [DW-1:0]   buf_q [N];
    logic [IW-1:0]   idx_q;
    logic [IW-1:0]   idx_d;
    logic [DW-1:0]   out_dat_q;
    logic            out_valid_q;
    logic            out_last_q;
    logic            busy_q;
    logic            drain_done_q;
    logic            err_q;
    logic            overrun_q;
    logic            comp_done_q;
    logic            trigger;

    assign trigger = comp_done & ~comp_done_q;
    assign idx_d   = idx_q + 1'b1;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q      <= IDLE;
            for (int i = 0; i < N; i++) begin
                buf_q[i] <= '0;
            end
            idx_q        <= '0;
            out_dat_q    <= '0;
            out_valid_q  <= 1'b0;
            out_last_q   <= 1'b0;
            busy_q       <= 1'b0;
            drain_done_q <= 1'b0;
            err_q        <= 1'b0;
            overrun_q    <= 1'b0;
            comp_done_q  <= 1'b0;
        end else begin
            comp_done_q <= comp_done;
            case (state_q)
                // DONE behaves like IDLE for triggers, so a back-to-back
                // capture right after drain_done is not lost.
                IDLE, DONE: begin
                    drain_done_q <= 1'b0;
                    if (trigger) begin
                        for (int i = 0; i < N; i++) begin
                            buf_q[i] <= res_in[i*DW +: DW];
                        end
                        err_q       <= error_in;
                        idx_q       <= '0;
                        out_dat_q   <= res_in[DW-1:0];
                        out_last_q  <= (N == 1);
                        out_valid_q <= 1'b1;
                        busy_q      <= 1'b1;
                        state_q     <= SEND;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                SEND: begin
                    // New results arriving mid-stream are dropped; the
                    // buffer keeps the capture currently being streamed.
                    if (trigger) begin
                        overrun_q <= 1'b1;
                    end
                    if (out_ready) begin
                        if (idx_q == LAST_IDX) begin
                            out_valid_q  <= 1'b0;
                            out_last_q   <= 1'b0;
                            busy_q       <= 1'b0;
                            drain_done_q <= 1'b1;
                            state_q      <= DONE;
                        end else begin
                            idx_q      <= idx_d;
                            out_dat_q  <= buf_q[idx_d];
                            out_last_q <= (idx_d == LAST_IDX);
                        end
                    end
                end
                default: begin
                    out_valid_q  <= 1'b0;
                    busy_q       <= 1'b0;
                    drain_done_q <= 1'b0;
                    state_q      <= IDLE;
                end
            endcase
        end
    end

    assign out_dat    = out_dat_q;
    assign out_valid  = out_valid_q;
    assign out_last   = out_last_q;
    assign out_idx    = idx_q;
    assign busy       = busy_q;
    assign drain_done = drain_done_q;
    assign err_out    = err_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_sys_arr_result_drain.sv
// tb/tb_sys_arr_result_drain.sv - scoreboard bench for sys_arr_result_drain
module tb_sys_arr_result_drain;

    localparam int M  = 2;
    localparam int K  = 2;
    localparam int DW = 32;

    logic            clk;
    logic            nrst;
    logic            comp_done;
    logic            error_in;
    logic [127:0]    res_in;
    logic [31:0]     out_dat;
    logic            out_valid;
    logic            out_ready;
    logic            out_last;
    logic [1:0]      out_idx;
    logic            busy;
    logic            drain_done;
    logic            err_out;
    logic            overrun;

    // r1c1, r1c0, r0c1, r0c0 = 77.0, 32.0, 32.0, 14.0
    localparam logic [127:0] V1 = {32'h429A0000, 32'h42000000, 32'h42000000, 32'h41600000};
    // r1c1, r1c0, r0c1, r0c0 = 4.0, 3.0, 2.0, 1.0
    localparam logic [127:0] V2 = {32'h40800000, 32'h40400000, 32'h40000000, 32'h3F800000};

    typedef struct {
        logic [31:0] dat;
        logic [1:0]  idx;
        logic        last;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   lat;

    sys_arr_result_drain #(.M(M), .K(K), .DW(DW)) dut (
        .clk        (clk),
        .nrst       (nrst),
        .comp_done  (comp_done),
        .error_in   (error_in),
        .res_in     (res_in),
        .out_dat    (out_dat),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_last   (out_last),
        .out_idx    (out_idx),
        .busy       (busy),
        .drain_done (drain_done),
        .err_out    (err_out),
        .overrun    (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_vec(input logic [127:0] v);
        exp_t e;
        for (int i = 0; i < 4; i++) begin
            e.dat  = v[i*32 +: 32];
            e.idx  = 2'(i);
            e.last = (i == 3);
            exp_q.push_back(e);
        end
    endtask

    // Drop comp_done for a cycle, then raise it with the given data.
    task automatic fire(input logic [127:0] v, input logic err);
        comp_done = 1'b0;
        cyc(1);
        res_in    = v;
        error_in  = err;
        push_vec(v);
        comp_done = 1'b1;
    endtask

    task automatic wait_drain(input string name, output int cycles);
        logic seen;
        seen   = 1'b0;
        cycles = 0;
        while (!seen && cycles < 40) begin
            cyc(1);
            cycles++;
            if (drain_done) seen = 1'b1;
        end
        if (!seen) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_timeout: drain_done not seen in %0d cycles", name, cycles);
        end
        chk({name, "_valid_at_done"}, 64'(out_valid), 64'd0);
        chk({name, "_busy_at_done"}, 64'(busy), 64'd0);
        chk({name, "_queue_empty"}, 64'(exp_q.size()), 64'd0);
        cyc(1);
        chk({name, "_done_pulse"}, 64'(drain_done), 64'd0);
    endtask

    // Scoreboard monitor: every accepted element must match the queue head.
    always @(negedge clk) begin
        if (nrst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL stream_extra: got unexpected element 0x%0h idx %0d", out_dat, out_idx);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("stream_dat", 64'(out_dat), 64'(e.dat));
                chk("stream_idx", 64'(out_idx), 64'(e.idx));
                chk("stream_last", 64'(out_last), 64'(e.last));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        nrst      = 1'b0;
        comp_done = 1'b0;
        error_in  = 1'b0;
        res_in    = '0;
        out_ready = 1'b1;
        cyc(2);

        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_dat", 64'(out_dat), 64'd0);
        chk("rst_idx", 64'(out_idx), 64'd0);
        chk("rst_last", 64'(out_last), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(drain_done), 64'd0);
        chk("rst_err", 64'(err_out), 64'd0);
        chk("rst_ovr", 64'(overrun), 64'd0);
        nrst = 1'b1;
        cyc(1);

        // Basic drain: four back-to-back elements, drain_done on cycle t+5.
        fire(V1, 1'b0);
        cyc(1);
        chk("basic_first_valid", 64'(out_valid), 64'd1);
        chk("basic_first_busy", 64'(busy), 64'd1);
        wait_drain("basic", lat);
        chk("basic_latency", 64'(lat), 64'd4);

        // Backpressure at idx 1, with res_in cleared mid-stream.
        fire(V1, 1'b0);
        cyc(1);
        res_in = '0;
        cyc(1);
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc(1);
            chk("stall_dat", 64'(out_dat), 64'h42000000);
            chk("stall_valid", 64'(out_valid), 64'd1);
            chk("stall_idx", 64'(out_idx), 64'd1);
        end
        out_ready = 1'b1;
        wait_drain("stall", lat);

        // Overrun: second comp_done rise while idx 1 is presented.
        fire(V2, 1'b0);
        cyc(1);
        comp_done = 1'b0;
        res_in    = V1;
        cyc(1);
        chk("ovr_pre", 64'(overrun), 64'd0);
        comp_done = 1'b1;
        cyc(1);
        chk("ovr_set", 64'(overrun), 64'd1);
        chk("ovr_idx", 64'(out_idx), 64'd2);
        wait_drain("ovr", lat);
        chk("ovr_idle_valid", 64'(out_valid), 64'd0);
        chk("ovr_sticky", 64'(overrun), 64'd1);

        // Error latch: held through and after the drain, cleared by a clean capture.
        fire(V1, 1'b1);
        cyc(1);
        error_in = 1'b0;
        chk("err_during", 64'(err_out), 64'd1);
        wait_drain("err", lat);
        cyc(3);
        chk("err_hold", 64'(err_out), 64'd1);
        fire(V2, 1'b0);
        cyc(1);
        chk("err_clear", 64'(err_out), 64'd0);
        wait_drain("err2", lat);

        // Asynchronous reset while idx 2 is presented.
        fire(V1, 1'b0);
        cyc(3);
        chk("rstm_idx_before", 64'(out_idx), 64'd2);
        #2;
        nrst      = 1'b0;
        comp_done = 1'b0;
        exp_q.delete();
        #1;
        chk("rstm_valid", 64'(out_valid), 64'd0);
        chk("rstm_busy", 64'(busy), 64'd0);
        chk("rstm_ovr", 64'(overrun), 64'd0);
        chk("rstm_idx", 64'(out_idx), 64'd0);
        for (int i = 0; i < 3; i++) begin
            cyc(1);
            chk("rstm_no_done", 64'(drain_done), 64'd0);
        end
        nrst = 1'b1;
        cyc(1);
        chk("rstm_after_done", 64'(drain_done), 64'd0);
        chk("rstm_after_valid", 64'(out_valid), 64'd0);
        fire(V2, 1'b0);
        cyc(1);
        chk("rstm_restart_idx", 64'(out_idx), 64'd0);
        chk("rstm_restart_valid", 64'(out_valid), 64'd1);
        wait_drain("restart", lat);

        comp_done = 1'b0;
        cyc(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
